// File: rtl/sar_search_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sar_search_ctrl                                             |
// | Description : Binary-search initiator. Drives a registered guess onto the |
// |               B side of a magnitude comparator and narrows [lo, hi] from  |
// |               its gt/eq/ls flags until the A-side value is located.       |
// | Options     : SAR_ITER_CNT_EN adds an iter_cnt output and a compare-count |
// |               timeout (WIDTH+2 compares ends the search with an error).   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_ls,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
`ifdef SAR_ITER_CNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] iter_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Bounds and sums carry one extra bit so guess+1 at the top and the
  // midpoint sums never wrap.
  localparam logic [WIDTH-1:0] MAX_G      = '1;
  localparam logic [WIDTH:0]   MAX_W      = {1'b0, MAX_G};
  localparam logic [WIDTH:0]   ONE_W      = 1;
  localparam logic [WIDTH-1:0] GUESS_INIT = MAX_G >> 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             error_q, error_d;
  logic [WIDTH:0]   lo_q, lo_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic             take_err;

  logic [WIDTH:0]   guess_w;
  logic [WIDTH:0]   next_lo;
  logic [WIDTH:0]   next_hi;
  logic [WIDTH:0]   sum_gt;
  logic [WIDTH:0]   sum_ls;

`ifdef SAR_ITER_CNT_EN
  localparam int              CNT_W      = $clog2(WIDTH+2);
  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(WIDTH+1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  logic [CNT_W-1:0] iter_q, iter_d;
`endif

  // Candidate bounds and midpoints for the gt / ls narrowing steps.
  always_comb begin
    guess_w = {1'b0, guess_q};
    next_lo = guess_w + ONE_W;
    next_hi = guess_w - ONE_W;
    sum_gt  = next_lo + hi_q;
    sum_ls  = lo_q + next_hi;
  end

  // Next-state and datapath update: one compare per SEARCH cycle.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    take_err = 1'b0;
`ifdef SAR_ITER_CNT_EN
    iter_d   = iter_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEARCH;
          lo_d    = '0;
          hi_d    = MAX_W;
          guess_d = GUESS_INIT;
          found_d = 1'b0;
          error_d = 1'b0;
`ifdef SAR_ITER_CNT_EN
          iter_d  = '0;
`endif
        end
      end
      S_SEARCH: begin
`ifdef SAR_ITER_CNT_EN
        iter_d = iter_q + CNT_ONE;
        if (iter_q == ITER_LIMIT) begin
          take_err = 1'b1;
        end else
`endif
        case ({cmp_gt, cmp_eq, cmp_ls})
          3'b010: begin
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = S_DONE;
          end
          3'b100: begin
            if ((guess_q == MAX_G) || (next_lo > hi_q)) begin
              take_err = 1'b1;
            end else begin
              lo_d    = next_lo;
              guess_d = WIDTH'(sum_gt >> 1);
            end
          end
          3'b001: begin
            // guess==0 must be caught explicitly: next_hi wraps to all ones.
            if ((guess_q == '0) || (lo_q > next_hi)) begin
              take_err = 1'b1;
            end else begin
              hi_d    = next_hi;
              guess_d = WIDTH'(sum_ls >> 1);
            end
          end
          default: take_err = 1'b1;
        endcase
        if (take_err) begin
          result_d = guess_q;
          found_d  = 1'b0;
          error_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
      lo_q     <= '0;
      hi_q     <= MAX_W;
`ifdef SAR_ITER_CNT_EN
      iter_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      found_q  <= found_d;
      error_q  <= error_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
`ifdef SAR_ITER_CNT_EN
      iter_q   <= iter_d;
`endif
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign found  = found_q;
  assign error  = error_q;
  assign busy   = (state_q == S_SEARCH);
  assign done   = (state_q == S_DONE);
`ifdef SAR_ITER_CNT_EN
  assign iter_cnt = iter_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sar_search_ctrl                                          |
// | Description : Self-checking bench for sar_search_ctrl (WIDTH=4) with a    |
// |               combinational comparator model and a result scoreboard.     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sar_search_ctrl;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic            found;
    logic            error;
    logic [3:0]      result;
    logic [3:0]      k;
    logic [7:0][3:0] g;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       target = '0;
  int               mode = 0;
  logic             cmp_gt, cmp_eq, cmp_ls;
  logic [WIDTH-1:0] guess;
  logic             busy, done, found, error;
  logic [WIDTH-1:0] result;
`ifdef SAR_ITER_CNT_EN
  logic [2:0]       iter_cnt;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [3:0] seen[$];

  always #5 clk = ~clk;

  // Comparator model; mode 1 forces gt+eq, mode 2 forces gt, mode 3 no flags.
  always_comb begin
    cmp_gt = (target > guess);
    cmp_eq = (target == guess);
    cmp_ls = (target < guess);
    if (mode == 1) begin
      cmp_gt = 1'b1; cmp_eq = 1'b1; cmp_ls = 1'b0;
    end else if (mode == 2) begin
      cmp_gt = 1'b1; cmp_eq = 1'b0; cmp_ls = 1'b0;
    end else if (mode == 3) begin
      cmp_gt = 1'b0; cmp_eq = 1'b0; cmp_ls = 1'b0;
    end
  end

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_ls (cmp_ls),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .error  (error),
    .result (result)
`ifdef SAR_ITER_CNT_EN
    ,
    .iter_cnt (iter_cnt)
`endif
  );

  // Plain binary search over 0..15 as written in the algorithm description.
  function automatic exp_t model(input logic [3:0] t);
    exp_t e;
    int lo, hi, g, k;
    e  = '0;
    lo = 0; hi = 15; g = 7; k = 0;
    for (int i = 0; i < 8; i++) begin
      e.g[i] = 4'(g);
      k++;
      if (int'(t) == g) break;
      if (int'(t) > g) lo = g + 1;
      else             hi = g - 1;
      g = (lo + hi) / 2;
    end
    e.found  = 1'b1;
    e.result = t;
    e.k      = 4'(k);
    return e;
  endfunction

  // Launch one search, collect guesses, compare against the scoreboard entry.
  task automatic run_search(input logic [3:0] tgt, input int md, input exp_t e,
                            input bit poke_start);
    exp_t x;
    int   edges;
    target = tgt;
    mode   = md;
    start  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    seen.delete();
    while (!done && edges < 20) begin
      if (busy) begin
        seen.push_back(guess);
        start = (poke_start && seen.size() == 2);
      end
      @(negedge clk);
      edges++;
    end
    x = sb.pop_front();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout tgt=%0d: done=%b expected 1", tgt, done);
    end
    n_checks++;
    if (found !== x.found) begin
      n_fail++;
      $display("FAIL found tgt=%0d: got %b expected %b", tgt, found, x.found);
    end
    n_checks++;
    if (error !== x.error) begin
      n_fail++;
      $display("FAIL error tgt=%0d: got %b expected %b", tgt, error, x.error);
    end
    n_checks++;
    if (result !== x.result) begin
      n_fail++;
      $display("FAIL result tgt=%0d: got %0d expected %0d", tgt, result, x.result);
    end
    n_checks++;
    if (edges !== int'(x.k) + 1) begin
      n_fail++;
      $display("FAIL latency tgt=%0d: got %0d expected %0d", tgt, edges, int'(x.k) + 1);
    end
    n_checks++;
    if (seen.size() !== int'(x.k)) begin
      n_fail++;
      $display("FAIL compares tgt=%0d: got %0d expected %0d", tgt, seen.size(), x.k);
    end
    for (int i = 0; i < seen.size() && i < 8; i++) begin
      n_checks++;
      if (seen[i] !== x.g[i]) begin
        n_fail++;
        $display("FAIL guess[%0d] tgt=%0d: got %0d expected %0d", i, tgt, seen[i], x.g[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_done tgt=%0d: got %b expected 0", tgt, busy);
    end
`ifdef SAR_ITER_CNT_EN
    n_checks++;
    if (iter_cnt !== 3'(x.k)) begin
      n_fail++;
      $display("FAIL iter_cnt tgt=%0d: got %0d expected %0d", tgt, iter_cnt, x.k);
    end
`endif
    // Start during DONE must not restart the search.
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse tgt=%0d: got %b expected 0", tgt, done);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_ignored tgt=%0d: busy=%b expected 0", tgt, busy);
    end
    n_checks++;
    if (result !== x.result) begin
      n_fail++;
      $display("FAIL result_hold tgt=%0d: got %0d expected %0d", tgt, result, x.result);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({guess, result, busy, done, found, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {guess, result, busy, done, found, error});
    end
`ifdef SAR_ITER_CNT_EN
    n_checks++;
    if (iter_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_iter_cnt: got %0d expected 0", iter_cnt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_target_7();
    exp_t e;
    e = '0; e.found = 1'b1; e.result = 4'd7; e.k = 4'd1; e.g[0] = 4'd7;
    run_search(4'd7, 0, e, 1'b0);
  endtask

  task automatic test_target_15();
    exp_t e;
    e = '0; e.found = 1'b1; e.result = 4'd15; e.k = 4'd5;
    e.g[0] = 4'd7; e.g[1] = 4'd11; e.g[2] = 4'd13; e.g[3] = 4'd14; e.g[4] = 4'd15;
    run_search(4'd15, 0, e, 1'b0);
  endtask

  task automatic test_target_0();
    exp_t e;
    e = '0; e.found = 1'b1; e.result = 4'd0; e.k = 4'd4;
    e.g[0] = 4'd7; e.g[1] = 4'd3; e.g[2] = 4'd1; e.g[3] = 4'd0;
    run_search(4'd0, 0, e, 1'b0);
  endtask

  task automatic test_all_targets();
    for (int t = 0; t < 16; t++) begin
      run_search(4'(t), 0, model(4'(t)), 1'b0);
    end
  endtask

  task automatic test_flags_not_onehot();
    exp_t e;
    e = '0; e.error = 1'b1; e.result = 4'd7; e.k = 4'd1; e.g[0] = 4'd7;
    run_search(4'd9, 1, e, 1'b0);
    run_search(4'd9, 3, e, 1'b0);
  endtask

  task automatic test_gt_saturate();
    exp_t e;
    e = '0; e.error = 1'b1; e.result = 4'd15; e.k = 4'd5;
    e.g[0] = 4'd7; e.g[1] = 4'd11; e.g[2] = 4'd13; e.g[3] = 4'd14; e.g[4] = 4'd15;
    run_search(4'd3, 2, e, 1'b0);
  endtask

  task automatic test_reset_mid_search();
    int done_seen;
    target = 4'd15;
    mode   = 0;
    start  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (guess !== 4'd13 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL third_compare: guess=%0d busy=%b expected 13/1", guess, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({guess, result, busy, done, found, error} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {guess, result, busy, done, found, error});
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d active cycles expected 0", done_seen);
    end
    run_search(4'd9, 0, model(4'd9), 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_search(4'd12, 0, model(4'd12), 1'b1);
    run_search(4'd2, 0, model(4'd2), 1'b1);
  endtask

  initial begin
    test_reset();
    test_target_7();
    test_target_15();
    test_target_0();
    test_flags_not_onehot();
    test_gt_saturate();
    test_reset_mid_search();
    test_start_while_busy();
    test_all_targets();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
